// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types for the instruction fetch queue: entry state
//                encoding, fetch exception codes and the stored entry record.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Lifecycle of one queue slot
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_READY   = 2'd2
    } entry_state_e;

    // Fetch exception codes carried alongside a PC
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_TLBL = 5'd2;

    // One buffered fetch: PC, fetched word and exception tag
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [4:0]  exccode;
        logic        exc_miss;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_queue_if
//  Description : Instruction bus between the fetch queue (master) and the
//                instruction memory / cache (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_queue_if;

    logic        inst_req;
    logic        inst_cache;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_cache,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_cache,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface
`default_nettype wire

// File: rtl/inst_fetch_queue_fq_store.sv
`default_nettype none
// ============================================================================
//  Module      : fq_store
//  Description : Entry payload array for the fetch queue. One port writes a
//                whole entry at the tail, one port fills in the fetched word
//                at the pend slot, and the head entry is read out.
//  Revision    : 1.0 - initial release
// ============================================================================
module fq_store
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_wr_tail_en,
    input  wire logic [PTR_W-1:0] i_wr_tail_idx,
    input  wire entry_t           i_wr_tail_data,
    input  wire logic             i_wr_pend_en,
    input  wire logic [PTR_W-1:0] i_wr_pend_idx,
    input  wire logic [31:0]      i_wr_pend_inst,
    input  wire logic [PTR_W-1:0] i_rd_idx,
    output entry_t                o_rd_data
);

    entry_t r_mem [DEPTH];

    // Tail and pend never address the same slot (EMPTY vs PENDING), so the
    // two writes are independent.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_wr_tail_en) begin
                r_mem[i_wr_tail_idx] <= i_wr_tail_data;
            end
            if (i_wr_pend_en) begin
                r_mem[i_wr_pend_idx].inst <= i_wr_pend_inst;
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_queue
//  Description : Multi-outstanding in-order instruction fetch queue. Issues
//                bus requests, buffers returned words with PC/exception tags
//                and hands them to decode in order; flush drops all entries
//                and silently discards responses still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       pc_valid_i,
    input  wire logic [31:0]                pc_i,
    input  wire logic [31:0]                paddr_i,
    input  wire logic                       cache_i,
    input  wire logic                       exc_i,
    input  wire logic [4:0]                 exccode_i,
    input  wire logic                       exc_miss_i,
    output logic                            pc_ready_o,
    inst_fetch_queue_if.master              bus,
    input  wire logic                       flush_i,
    output logic                            out_valid_o,
    input  wire logic                       out_ready_i,
    output logic [31:0]                     out_pc_o,
    output logic [31:0]                     out_inst_o,
    output logic                            out_exc_o,
    output logic [4:0]                      out_exccode_o,
    output logic                            out_exc_miss_o,
    output logic [$clog2(DEPTH+1)-1:0]      count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OST_W = $clog2(MAX_OUTSTANDING + 1);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_pend;
    logic [CNT_W-1:0] r_count;
    logic [OST_W-1:0] r_outstanding;
    logic [OST_W-1:0] r_discard;
    entry_state_e     r_state     [DEPTH];
    entry_state_e     w_state_nxt [DEPTH];

    logic             w_full;
    logic             w_room;
    logic             w_enq_bus;
    logic             w_enq_exc;
    logic             w_enq;
    logic             w_deq;
    logic             w_rsp_drop;
    logic             w_rsp_live;
    logic [CNT_W-1:0] w_live_cnt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [PTR_W-1:0] w_pend_nxt;
    logic [PTR_W-1:0] w_scan_idx;
    logic             w_pend_found;
    logic [OST_W-1:0] w_discard_nxt;
    logic [OST_W-1:0] w_outstanding_nxt;
    entry_t           w_tail_data;
    entry_t           w_head_data;

    // Acceptance: bus requests need room in both the queue and the bus
    // window; exception requests only need queue room and never touch the bus.
    assign w_full         = (r_count == CNT_W'(DEPTH));
    assign w_room         = (r_outstanding < OST_W'(MAX_OUTSTANDING));
    assign bus.inst_req   = pc_valid_i & ~exc_i & ~w_full & w_room & ~flush_i & ~reset;
    assign bus.inst_cache = cache_i;
    assign bus.inst_addr  = paddr_i;
    assign w_enq_bus      = bus.inst_req & bus.inst_addr_ok;
    assign w_enq_exc      = pc_valid_i & exc_i & ~w_full & ~flush_i & ~reset;
    assign w_enq          = w_enq_bus | w_enq_exc;
    assign pc_ready_o     = w_enq;

    assign out_valid_o    = (r_state[r_head] == ST_READY);
    assign w_deq          = out_valid_o & out_ready_i;

    // Responses owed to flushed requests are swallowed first; a live response
    // in the flush cycle is dropped too since its entry is being cleared.
    assign w_rsp_drop     = bus.inst_data_ok & (r_discard != '0);
    assign w_rsp_live     = bus.inst_data_ok & (r_discard == '0) & ~flush_i;

    // Count of entries still waiting for their bus response
    always_comb begin
        w_live_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_state[i] == ST_PENDING) begin
                w_live_cnt = w_live_cnt + CNT_W'(1);
            end
        end
    end

    // Per-slot state update for this cycle's response, dequeue and enqueue
    always_comb begin
        w_state_nxt = r_state;
        if (w_rsp_live) begin
            w_state_nxt[r_pend] = ST_READY;
        end
        if (w_deq) begin
            w_state_nxt[r_head] = ST_EMPTY;
        end
        if (w_enq_bus) begin
            w_state_nxt[r_tail] = ST_PENDING;
        end else if (w_enq_exc) begin
            w_state_nxt[r_tail] = ST_READY;
        end
    end

    // Pend tracks the oldest PENDING slot; with none left it parks at the
    // tail so the next bus request becomes the response target, while an
    // exception entry written there is stepped over.
    always_comb begin
        w_tail_nxt   = r_tail + PTR_W'(w_enq);
        w_pend_nxt   = w_tail_nxt;
        w_pend_found = 1'b0;
        w_scan_idx   = r_pend;
        for (int i = 0; i < DEPTH; i++) begin
            w_scan_idx = r_pend + PTR_W'(i);
            if (!w_pend_found && (w_state_nxt[w_scan_idx] == ST_PENDING)) begin
                w_pend_nxt   = w_scan_idx;
                w_pend_found = 1'b1;
            end
        end
    end

    // In-flight bookkeeping. On flush every live pending request turns into
    // a discard; the response arriving in the same cycle (live or already
    // discarded) retires one of them.
    always_comb begin
        w_outstanding_nxt = r_outstanding + OST_W'(w_enq_bus) - OST_W'(bus.inst_data_ok);
        if (flush_i) begin
            w_discard_nxt = r_discard + OST_W'(w_live_cnt) - OST_W'(bus.inst_data_ok);
        end else begin
            w_discard_nxt = r_discard - OST_W'(w_rsp_drop);
        end
    end

    // Pointer, occupancy and slot-state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_pend        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ST_EMPTY;
            end
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            if (flush_i) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_pend  <= '0;
                r_count <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_state[i] <= ST_EMPTY;
                end
            end else begin
                r_head  <= r_head + PTR_W'(w_deq);
                r_tail  <= w_tail_nxt;
                r_pend  <= w_pend_nxt;
                r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
                r_state <= w_state_nxt;
            end
        end
    end

    // New entry record; bus fetches carry clean exception fields
    always_comb begin
        w_tail_data          = '0;
        w_tail_data.pc       = pc_i;
        w_tail_data.exc      = w_enq_exc;
        w_tail_data.exccode  = w_enq_exc ? exccode_i : 5'd0;
        w_tail_data.exc_miss = w_enq_exc & exc_miss_i;
    end

    fq_store #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_store (
        .clk            (clk),
        .reset          (reset),
        .i_wr_tail_en   (w_enq),
        .i_wr_tail_idx  (r_tail),
        .i_wr_tail_data (w_tail_data),
        .i_wr_pend_en   (w_rsp_live),
        .i_wr_pend_idx  (r_pend),
        .i_wr_pend_inst (bus.inst_rdata),
        .i_rd_idx       (r_head),
        .o_rd_data      (w_head_data)
    );

    assign out_pc_o       = w_head_data.pc;
    assign out_inst_o     = w_head_data.inst;
    assign out_exc_o      = w_head_data.exc;
    assign out_exccode_o  = w_head_data.exccode;
    assign out_exc_miss_o = w_head_data.exc_miss;
    assign count_o        = r_count;

    // Every outstanding bus request is either owned by a pending entry or
    // waiting to be discarded, and the bus window is never exceeded.
    a_inflight_balance : assert property (@(posedge clk) disable iff (reset)
        ((32'(w_live_cnt) + 32'(r_discard)) == 32'(r_outstanding)) &&
        (32'(r_outstanding) <= MAX_OUTSTANDING));

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_queue
//  Description : Scoreboard bench for inst_fetch_queue. Accepted requests
//                push their expected output; a monitor pops and compares on
//                every decode handshake. A small bus model answers requests
//                in order, one cycle after address acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;
    import fetch_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [4:0]  code;
        logic        miss;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_valid;
    logic [31:0] pc;
    logic [31:0] paddr;
    logic        cache;
    logic        exc;
    logic [4:0]  exccode;
    logic        exc_miss;
    logic        pc_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_exc;
    logic [4:0]  out_exccode;
    logic        out_miss;
    logic [2:0]  count;

    logic        resp_en;
    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        exp_q[$];
    logic [31:0] bus_q[$];

    inst_fetch_queue_if bus_if ();

    inst_fetch_queue #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_valid_i     (pc_valid),
        .pc_i           (pc),
        .paddr_i        (paddr),
        .cache_i        (cache),
        .exc_i          (exc),
        .exccode_i      (exccode),
        .exc_miss_i     (exc_miss),
        .pc_ready_o     (pc_ready),
        .bus            (bus_if),
        .flush_i        (flush),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_pc_o       (out_pc),
        .out_inst_o     (out_inst),
        .out_exc_o      (out_exc),
        .out_exccode_o  (out_exccode),
        .out_exc_miss_o (out_miss),
        .count_o        (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h2400_1013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    // Bus slave: addresses accepted in one cycle are answered in order from
    // the next cycle on, while resp_en allows; reset empties it.
    logic        s_rst, s_acc, s_dok;
    logic [31:0] s_addr;
    initial begin
        bus_if.inst_data_ok = 1'b0;
        bus_if.inst_rdata   = '0;
        forever begin
            @(negedge clk);
            s_rst  = reset;
            s_acc  = bus_if.inst_req & bus_if.inst_addr_ok;
            s_addr = bus_if.inst_addr;
            s_dok  = bus_if.inst_data_ok;
            @(posedge clk);
            #2;
            if (s_rst) begin
                bus_q.delete();
            end else begin
                if (s_dok && bus_q.size() > 0) bus_q.delete(0);
                if (s_acc) bus_q.push_back(s_addr);
            end
            if (!s_rst && resp_en && bus_q.size() > 0) begin
                bus_if.inst_data_ok = 1'b1;
                bus_if.inst_rdata   = word_of(bus_q[0]);
            end else begin
                bus_if.inst_data_ok = 1'b0;
                bus_if.inst_rdata   = '0;
            end
        end
    end

    // Monitor: every decode handshake must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL out_unexpected: actual pc %h inst %h, required no output", out_pc, out_inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_inst", out_inst, e.inst);
                chk("out_exc_fields", {25'd0, out_exc, out_exccode, out_miss},
                    {25'd0, e.exc, e.code, e.miss});
            end
        end
    end

    task automatic issue(input logic [31:0] a_pc, input logic a_exc, input logic [4:0] a_code,
                         input logic a_miss, input int budget);
        int   c    = 0;
        logic done = 1'b0;
        exp_t e;
        pc_valid = 1'b1;
        pc       = a_pc;
        paddr    = a_pc & 32'h1FFF_FFFF;
        cache    = ~a_pc[29];
        exc      = a_exc;
        exccode  = a_code;
        exc_miss = a_miss;
        while (!done && c < budget) begin
            @(negedge clk);
            if (pc_ready) begin
                done   = 1'b1;
                e.pc   = a_pc;
                e.inst = a_exc ? 32'd0 : word_of(a_pc & 32'h1FFF_FFFF);
                e.exc  = a_exc;
                e.code = a_exc ? a_code : 5'd0;
                e.miss = a_exc & a_miss;
                exp_q.push_back(e);
                if (a_exc) begin
                    chk("exc_no_bus_req", {31'd0, bus_if.inst_req}, 32'd0);
                end else begin
                    chk("bus_addr", bus_if.inst_addr, a_pc & 32'h1FFF_FFFF);
                    chk("bus_cache", {31'd0, bus_if.inst_cache}, {31'd0, ~a_pc[29]});
                end
            end
            @(posedge clk);
            #1;
            c++;
        end
        pc_valid = 1'b0;
        exc      = 1'b0;
        exccode  = 5'd0;
        exc_miss = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL issue_timeout: pc %h not accepted, required acceptance within %0d cycles", a_pc, budget);
        end
    endtask

    task automatic stream(input int n, input logic [31:0] base, input int budget);
        for (int k = 0; k < n; k++) issue(base + 32'(4 * k), 1'b0, 5'd0, 1'b0, budget);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_count"}, {29'd0, count}, 32'd0);
        chk({tag, "_out_pc"}, out_pc, 32'd0);
        chk({tag, "_out_inst"}, out_inst, 32'd0);
        chk({tag, "_out_exc"}, {25'd0, out_exc, out_exccode, out_miss}, 32'd0);
        chk({tag, "_inst_req"}, {31'd0, bus_if.inst_req}, 32'd0);
        chk({tag, "_pc_ready"}, {31'd0, pc_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; pc_valid = 1'b1; pc = 32'hBFC0_0000; paddr = 32'h1FC0_0000;
        cache = 1'b0; exc = 1'b0; exccode = 5'd0; exc_miss = 1'b0; flush = 1'b0;
        out_ready = 1'b1; resp_en = 1'b1;
        bus_if.inst_addr_ok = 1'b1;

        // Reset state, with a request offered to confirm it is held off
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0; pc_valid = 1'b0;
        @(posedge clk); #1;

        // Streaming: 8 fetches back to back, first output two cycles after addr_ok
        fork
            stream(8, 32'hBFC0_0000, 20);
            begin
                int t0 = -1;
                int t1 = -1;
                for (int k = 0; k < 30; k++) begin
                    @(negedge clk);
                    if (t0 < 0 && bus_if.inst_req && bus_if.inst_addr_ok) t0 = k;
                    if (t0 >= 0 && t1 < 0 && out_valid) t1 = k;
                end
                chk("first_out_latency", 32'(t1 - t0), 32'd2);
            end
        join
        drain(40);

        // Backpressure: queue fills to DEPTH, requests stall, order survives
        out_ready = 1'b0;
        fork
            stream(6, 32'hBFC0_0100, 40);
            begin
                repeat (12) @(posedge clk);
                @(negedge clk);
                chk("bp_count_full", {29'd0, count}, 32'd4);
                chk("bp_pc_ready", {31'd0, pc_ready}, 32'd0);
                chk("bp_inst_req", {31'd0, bus_if.inst_req}, 32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain(40);

        // Exception entry between two normal fetches
        issue(32'hBFC0_0500, 1'b0, 5'd0, 1'b0, 20);
        issue(32'hBFC0_0504, 1'b1, EXC_TLBL, 1'b1, 20);
        issue(32'hBFC0_0508, 1'b0, 5'd0, 1'b0, 20);
        drain(40);

        // Flush with three requests in flight and no responses yet
        resp_en = 1'b0;
        stream(3, 32'hBFC0_0200, 20);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_count", {29'd0, count}, 32'd0);
        @(posedge clk); #1;
        resp_en = 1'b1;
        issue(32'h8000_0180, 1'b0, 5'd0, 1'b0, 20);
        drain(40);

        // Flush in the same cycle as a live response, two pending
        resp_en = 1'b0;
        stream(2, 32'hBFC0_0300, 20);
        resp_en = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        chk("flush_dok_setup", {31'd0, bus_if.inst_data_ok}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        issue(32'h8000_0200, 1'b0, 5'd0, 1'b0, 20);
        drain(40);

        // Reset in the middle of a stream, then resume
        out_ready = 1'b0;
        stream(3, 32'hBFC0_0600, 20);
        reset = 1'b1; pc_valid = 1'b1; pc = 32'hBFC0_0610; paddr = 32'h1FC0_0610;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_outputs("midreset");
        @(posedge clk); #1;
        reset = 1'b0; pc_valid = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        stream(3, 32'hBFC0_0700, 20);
        drain(40);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
